// File: rtl/shift_pkg.sv
// Shared definitions for the Shift4 register stage and its upstream sequencer.
// Holds the sequencer state encoding and the default data/count widths.
package shift_pkg;

    localparam int SIZE_DEF  = 4;
    localparam int CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/shift_cnt.sv
// Loadable down-counter for the Shift4 sequencer: clamps the loaded count to
// SIZE, decrements on enable and flags the zero and one values.
module shift_cnt
    import shift_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             dec,
    output logic             is_zero,
    output logic             is_one
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SIZE);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = (ld_val > CNT_MAX) ? CNT_MAX : ld_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero = (cnt_q == '0);
    assign is_one  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift4_seq.sv
// Upstream sequencer for Shift4: accepts a word and shift count, then drives
// one load cycle, the requested number of (hold-pausable) shifts, and a done pulse.
module shift4_seq
    import shift_pkg::*;
#(
    parameter int size  = SIZE_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [size-1:0]  in_data,
    input  logic [CNT_W-1:0] in_shamt,
    input  logic             hold,
    output logic             load,
    output logic             ena,
    output logic [size-1:0]  data,
    output logic             busy,
    output logic             done
);

    state_e          state_d, state_q;
    logic [size-1:0] data_d, data_q;
    logic            cnt_ld, cnt_dec, cnt_is_zero, cnt_is_one;

    shift_cnt #(
        .SIZE  (size),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .ld      (cnt_ld),
        .ld_val  (in_shamt),
        .dec     (cnt_dec),
        .is_zero (cnt_is_zero),
        .is_one  (cnt_is_one)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        in_ready = 1'b0;
        load     = 1'b0;
        ena      = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        cnt_ld   = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_ld  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                state_d = cnt_is_zero ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                // hold gates ena combinationally and freezes both count and state
                ena     = !hold;
                cnt_dec = !hold;
                if (!hold && cnt_is_one) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data = data_q;

endmodule
